// File: rtl/joypad_responder_pkg.sv
// Shared definitions for the joypad responder: FSM encoding, button bit indices,
// default target address and bus ACK/NACK levels.
package joypad_responder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_TX,
      ST_TX_ACK,
      ST_IGNORE
   } state_t;

   localparam logic [6:0] DEFAULT_ADDR = 7'h52;

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   localparam logic ACK_LVL  = 1'b0;
   localparam logic NACK_LVL = 1'b1;
   localparam logic READ_BIT = 1'b1;

   localparam logic [3:0] LAST_BIT = 4'd8;

endpackage

// File: rtl/joypad_responder_bus_cond_detect.sv
// Synchronises SCL/SDA and derives SCL edges plus START/STOP conditions.
// Optional 3-sample majority glitch filter when JOYPAD_RESP_FILTER_EN is defined.
module bus_cond_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_in,
   input  logic sda_in,
   output logic sda,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync;
   logic [SYNC_STAGES-1:0] sda_sync;
   logic                   scl_lvl;
   logic                   sda_lvl;
   logic                   scl_prev;
   logic                   sda_prev;

   // Idle bus is high on both lines, so reset the chains to 1 to avoid a false edge
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync <= '1;
         sda_sync <= '1;
      end else begin
         scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
         sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
      end
   end

`ifdef JOYPAD_RESP_FILTER_EN
   logic [2:0] scl_hist;
   logic [2:0] sda_hist;
   logic       scl_filt;
   logic       sda_filt;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_hist <= '1;
         sda_hist <= '1;
         scl_filt <= 1'b1;
         sda_filt <= 1'b1;
      end else begin
         scl_hist <= {scl_hist[1:0], scl_sync[SYNC_STAGES-1]};
         sda_hist <= {sda_hist[1:0], sda_sync[SYNC_STAGES-1]};
         scl_filt <= maj3(scl_hist);
         sda_filt <= maj3(sda_hist);
      end
   end

   assign scl_lvl = scl_filt;
   assign sda_lvl = sda_filt;
`else
   assign scl_lvl = scl_sync[SYNC_STAGES-1];
   assign sda_lvl = sda_sync[SYNC_STAGES-1];
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_prev <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_prev <= scl_lvl;
         sda_prev <= sda_lvl;
      end
   end

   // START/STOP require SCL high on both samples, so an SDA change racing an SCL edge is a data bit
   assign sda      = sda_lvl;
   assign scl_rise = scl_lvl & ~scl_prev;
   assign scl_fall = ~scl_lvl & scl_prev;
   assign start    = scl_lvl & scl_prev & sda_prev & ~sda_lvl;
   assign stop     = scl_lvl & scl_prev & ~sda_prev & sda_lvl;

endmodule

// File: rtl/joypad_responder.sv
// Read-only open-drain joypad target: matches DEV_ADDR and returns ~buttons MSB first.
// Define JOYPAD_RESP_FILTER_EN to add the SCL/SDA majority glitch filter.
module joypad_responder
   import joypad_responder_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR    = DEFAULT_ADDR,
   parameter int         SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] buttons,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       sda_out,
   output logic       busy,
   output logic       polled
);

   logic sda;
   logic scl_rise;
   logic scl_fall;
   logic start;
   logic stop;

   state_t     state, state_nxt;
   logic [7:0] shift_reg, shift_nxt;
   logic [3:0] bit_cnt, bit_cnt_nxt;
   logic [7:0] tx_byte, tx_byte_nxt;
   logic       ack_seen, ack_seen_nxt;
   logic       sda_out_nxt;
   logic       busy_nxt;
   logic       polled_nxt;

   bus_cond_detect #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_cond (
      .clk      (clk),
      .rst      (rst),
      .scl_in   (scl_in),
      .sda_in   (sda_in),
      .sda      (sda),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         shift_reg <= '0;
         bit_cnt   <= '0;
         ack_seen  <= 1'b0;
         sda_out   <= 1'b1;
         busy      <= 1'b0;
         polled    <= 1'b0;
      end else begin
         state     <= state_nxt;
         shift_reg <= shift_nxt;
         bit_cnt   <= bit_cnt_nxt;
         ack_seen  <= ack_seen_nxt;
         sda_out   <= sda_out_nxt;
         busy      <= busy_nxt;
         polled    <= polled_nxt;
      end
   end

   always_ff @(posedge clk) begin
      tx_byte <= tx_byte_nxt;
   end

   always_comb begin
      state_nxt    = state;
      shift_nxt    = shift_reg;
      bit_cnt_nxt  = bit_cnt;
      tx_byte_nxt  = tx_byte;
      ack_seen_nxt = ack_seen;
      sda_out_nxt  = sda_out;
      busy_nxt     = busy;
      polled_nxt   = 1'b0;

      if (start) begin
         state_nxt    = ST_ADDR;
         shift_nxt    = '0;
         bit_cnt_nxt  = '0;
         ack_seen_nxt = 1'b0;
         sda_out_nxt  = 1'b1;
         busy_nxt     = 1'b0;
      end else if (stop) begin
         state_nxt    = ST_IDLE;
         shift_nxt    = '0;
         bit_cnt_nxt  = '0;
         ack_seen_nxt = 1'b0;
         sda_out_nxt  = 1'b1;
         busy_nxt     = 1'b0;
      end else begin
         case (state)
            ST_ADDR: begin
               // The SCL fall right after START arrives with bit_cnt==0 and is ignored
               if (scl_rise && bit_cnt < LAST_BIT) begin
                  shift_nxt   = {shift_reg[6:0], sda};
                  bit_cnt_nxt = bit_cnt + 4'd1;
               end else if (scl_fall && bit_cnt == LAST_BIT) begin
                  bit_cnt_nxt = '0;
                  if (shift_reg == {DEV_ADDR, READ_BIT}) begin
                     state_nxt   = ST_ADDR_ACK;
                     sda_out_nxt = ACK_LVL;
                     busy_nxt    = 1'b1;
                     tx_byte_nxt = ~buttons;
                  end else begin
                     state_nxt = ST_IGNORE;
                  end
               end
            end
            ST_ADDR_ACK: begin
               if (scl_fall) begin
                  state_nxt   = ST_TX;
                  sda_out_nxt = tx_byte[7];
                  tx_byte_nxt = {tx_byte[6:0], 1'b0};
                  bit_cnt_nxt = 4'd1;
               end
            end
            ST_TX: begin
               if (scl_fall) begin
                  if (bit_cnt == LAST_BIT) begin
                     state_nxt    = ST_TX_ACK;
                     sda_out_nxt  = 1'b1;
                     bit_cnt_nxt  = '0;
                     ack_seen_nxt = 1'b0;
                  end else begin
                     sda_out_nxt = tx_byte[7];
                     tx_byte_nxt = {tx_byte[6:0], 1'b0};
                     bit_cnt_nxt = bit_cnt + 4'd1;
                  end
               end
            end
            ST_TX_ACK: begin
               // Next byte is snapshotted at the ACK sample so mid-byte button changes never leak in
               if (scl_rise) begin
                  polled_nxt = 1'b1;
                  if (sda == ACK_LVL) begin
                     ack_seen_nxt = 1'b1;
                     tx_byte_nxt  = ~buttons;
                  end else begin
                     state_nxt = ST_IGNORE;
                  end
               end else if (scl_fall && ack_seen) begin
                  state_nxt    = ST_TX;
                  ack_seen_nxt = 1'b0;
                  sda_out_nxt  = tx_byte[7];
                  tx_byte_nxt  = {tx_byte[6:0], 1'b0};
                  bit_cnt_nxt  = 4'd1;
               end
            end
            ST_IGNORE: begin
               sda_out_nxt = NACK_LVL;
            end
            ST_IDLE: begin
               sda_out_nxt = 1'b1;
            end
            default: begin
               state_nxt   = ST_IDLE;
               sda_out_nxt = 1'b1;
               busy_nxt    = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_joypad_responder.sv
// Bench for joypad_responder: bit-banged initiator on a wired-AND SDA line,
// table vectors, random transactions against a transaction-level model, corner sequences.
module tb_joypad_responder;

   localparam int H = 10;

   typedef struct packed {
      logic [7:0]      addr;
      logic [1:0]      nbytes;
      logic [2:0][7:0] btn;
      logic            ack;
      logic [2:0][7:0] exp_b;
      logic [1:0]      exp_polled;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_m;
   logic       sda_m;
   logic [7:0] buttons;
   logic       sda_bus;
   logic       sda_out;
   logic       busy;
   logic       polled;

   int tests = 0;
   int fails = 0;
   int polled_total = 0;
   int low_total = 0;
   int busy_total = 0;

   vec_t vecs [4];

   assign sda_bus = sda_m & sda_out;

   always #5 clk = ~clk;

   joypad_responder dut (
      .clk     (clk),
      .rst     (rst),
      .buttons (buttons),
      .scl_in  (scl_m),
      .sda_in  (sda_bus),
      .sda_out (sda_out),
      .busy    (busy),
      .polled  (polled)
   );

   always @(posedge clk) begin
      polled_total <= polled_total + (polled ? 1 : 0);
      low_total    <= low_total + (sda_out ? 0 : 1);
      busy_total   <= busy_total + (busy ? 1 : 0);
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_start();
      sda_m = 1'b1;
      scl_m = 1'b1;
      tick(H);
      sda_m = 1'b0;
      tick(H);
      scl_m = 1'b0;
      tick(H / 2);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0;
      tick(H / 2);
      scl_m = 1'b1;
      tick(H);
      sda_m = 1'b1;
      tick(H);
   endtask

   task automatic write_bit(input logic b);
      sda_m = b;
      tick(H / 2);
      scl_m = 1'b1;
      tick(H);
      scl_m = 1'b0;
      tick(H / 2);
   endtask

   task automatic read_bit(output logic b);
      sda_m = 1'b1;
      tick(H / 2);
      scl_m = 1'b1;
      tick(H / 2);
      b = sda_bus;
      tick(H / 2);
      scl_m = 1'b0;
      tick(H / 2);
   endtask

   task automatic send_addr(input logic [7:0] a);
      for (int i = 7; i >= 0; i--) write_bit(a[i]);
   endtask

   // Transaction-level expectation: acked only for a read to 0x52, each byte is the inverted button word
   function automatic vec_t model(input logic [7:0] addr, input logic [1:0] nbytes,
                                  input logic [2:0][7:0] btn);
      vec_t v;
      v.addr       = addr;
      v.nbytes     = nbytes;
      v.btn        = btn;
      v.ack        = (addr == {7'h52, 1'b1});
      for (int k = 0; k < 3; k++) v.exp_b[k] = ~btn[k];
      v.exp_polled = v.ack ? nbytes : 2'd0;
      return v;
   endfunction

   task automatic run_txn(input vec_t v);
      int         p0, l0, b0;
      logic       a, b, a_exp;
      logic [7:0] got;
      got = '0;
      a_exp = v.ack ? 1'b0 : 1'b1;
      buttons = v.btn[0];
      p0 = polled_total;
      l0 = low_total;
      b0 = busy_total;
      bus_start();
      send_addr(v.addr);
      read_bit(a);
      check("addr_ack", a, a_exp);
      if (v.ack) begin
         check("busy_after_match", busy, 1);
         for (int k = 0; k < int'(v.nbytes); k++) begin
            for (int i = 7; i >= 0; i--) begin
               read_bit(b);
               got[i] = b;
               if (i == 4 && k + 1 < int'(v.nbytes)) buttons = v.btn[k + 1];
            end
            check("data_byte", got, v.exp_b[k]);
            write_bit((k == int'(v.nbytes) - 1) ? 1'b1 : 1'b0);
         end
      end
      bus_stop();
      tick(H);
      check("polled_pulses", polled_total - p0, v.exp_polled);
      check("busy_after_stop", busy, 0);
      if (!v.ack) begin
         check("sda_never_low", low_total - l0, 0);
         check("busy_never_high", busy_total - b0, 0);
      end
   endtask

   initial begin
      logic       a, b;
      logic [7:0] got;
      logic [7:0] raddr;
      logic [1:0] rn;
      logic [2:0][7:0] rbtn;
      logic       glitch_busy_exp;

      got = '0;
      vecs[0] = '{addr: 8'hA5, nbytes: 2'd1, btn: {8'h00, 8'h00, 8'h81}, ack: 1'b1,
                  exp_b: {8'h00, 8'h00, 8'h7E}, exp_polled: 2'd1};
      vecs[1] = '{addr: 8'hA7, nbytes: 2'd1, btn: {8'h00, 8'h00, 8'h3C}, ack: 1'b0,
                  exp_b: {8'h00, 8'h00, 8'h00}, exp_polled: 2'd0};
      vecs[2] = '{addr: 8'hA4, nbytes: 2'd1, btn: {8'h00, 8'h00, 8'hFF}, ack: 1'b0,
                  exp_b: {8'h00, 8'h00, 8'h00}, exp_polled: 2'd0};
      vecs[3] = '{addr: 8'hA5, nbytes: 2'd2, btn: {8'h00, 8'h10, 8'h01}, ack: 1'b1,
                  exp_b: {8'h00, 8'hEF, 8'hFE}, exp_polled: 2'd2};

      rst = 1'b1;
      scl_m = 1'b1;
      sda_m = 1'b1;
      buttons = 8'h00;
      tick(2);
      check("reset_sda_out", sda_out, 1);
      check("reset_busy", busy, 0);
      check("reset_polled", polled, 0);
      rst = 1'b0;
      tick(20);
      check("idle_sda_out", sda_out, 1);
      check("idle_busy", busy, 0);

      for (int t = 0; t < 4; t++) run_txn(vecs[t]);

      for (int r = 0; r < 6; r++) begin
         raddr = ($urandom_range(0, 1) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
         rn    = 2'($urandom_range(1, 3));
         for (int k = 0; k < 3; k++) rbtn[k] = 8'($urandom_range(0, 255));
         run_txn(model(raddr, rn, rbtn));
      end

      // Repeated START while the responder is mid-byte (bit 3 released, upper nibble driven low)
      buttons = 8'hF7;
      bus_start();
      send_addr(8'hA5);
      read_bit(a);
      check("rs_first_ack", a, 0);
      for (int i = 7; i >= 4; i--) begin
         read_bit(b);
         got[i] = b;
      end
      check("rs_upper_nibble", got[7:4], 4'h0);
      sda_m = 1'b1;
      tick(H / 2);
      scl_m = 1'b1;
      tick(H / 2);
      sda_m = 1'b0;
      tick(H);
      check("rs_sda_released", sda_out, 1);
      check("rs_busy_cleared", busy, 0);
      scl_m = 1'b0;
      tick(H / 2);
      send_addr(8'hA5);
      read_bit(a);
      check("rs_second_ack", a, 0);
      check("rs_busy_again", busy, 1);
      for (int i = 7; i >= 0; i--) begin
         read_bit(b);
         got[i] = b;
      end
      check("rs_data_byte", got, 8'h08);
      write_bit(1'b1);
      bus_stop();
      tick(H);
      check("rs_busy_after_stop", busy, 0);

      // One-clock SDA glitch with SCL high during a released data bit
`ifdef JOYPAD_RESP_FILTER_EN
      glitch_busy_exp = 1'b1;
`else
      glitch_busy_exp = 1'b0;
`endif
      buttons = 8'h00;
      bus_start();
      send_addr(8'hA5);
      read_bit(a);
      check("gl_ack", a, 0);
      sda_m = 1'b1;
      tick(H / 2);
      scl_m = 1'b1;
      tick(H / 2);
      sda_m = 1'b0;
      tick(1);
      sda_m = 1'b1;
      tick(H / 2);
      scl_m = 1'b0;
      tick(H);
      check("gl_busy_after_glitch", busy, glitch_busy_exp);
      bus_stop();
      tick(H);
      check("gl_busy_after_stop", busy, 0);

      // Reset asserted while the responder is pulling SDA low
      buttons = 8'hFF;
      bus_start();
      send_addr(8'hA5);
      read_bit(a);
      check("rm_ack", a, 0);
      read_bit(b);
      check("rm_bit7", b, 0);
      tick(H / 2);
      check("rm_driving_low", sda_out, 0);
      rst = 1'b1;
      tick(1);
      check("rm_sda_released", sda_out, 1);
      check("rm_busy_cleared", busy, 0);
      rst = 1'b0;
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(2 * H);
      check("rm_idle_sda", sda_out, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
